// File: rtl/onewire_ds18b20_slave.sv
// onewire_ds18b20_slave: DS18B20 emulator on the FPGA side of a 1-Wire bus.
// Answers presence, Skip ROM, Convert T and Read Scratchpad with a serial CRC8.
module onewire_ds18b20_slave #(
    parameter int CLK_PER_US   = 1,
    parameter int RESET_MIN_US = 480,
    parameter int PRES_WAIT_US = 30,
    parameter int PRES_LEN_US  = 120,
    parameter int SAMPLE_US    = 30,
    parameter int CONV_US      = 750
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        I_ONE_WIRE,
    output logic        O_ONE_WIRE,
    input  logic [15:0] I_TEMP,
    output logic [7:0]  O_CMD,
    output logic        O_CMD_VALID,
    output logic        O_BUSY
);
    localparam int RESET_CYC = RESET_MIN_US * CLK_PER_US;
    localparam int PW_CYC    = PRES_WAIT_US * CLK_PER_US;
    localparam int PL_CYC    = PRES_LEN_US * CLK_PER_US;
    localparam int SMP_CYC   = SAMPLE_US * CLK_PER_US;
    localparam int CONV_CYC  = CONV_US * CLK_PER_US;
    localparam int LW = $clog2(RESET_CYC + 1);
    localparam int TW = $clog2(PW_CYC + PL_CYC + 1);
    localparam int SW = $clog2(SMP_CYC + 1);
    localparam int CW = $clog2(CONV_CYC + 1);

    typedef enum logic [2:0] {IDLE, PRES_WAIT, PRESENCE, ROM_CMD, FUNC_CMD, CONVERT, TX} state_t;
    state_t state, state_nx;

    logic [2:0]    sync;
    logic [LW-1:0] low_cnt;
    logic [TW-1:0] tmr;
    logic [SW-1:0] slot_cnt;
    logic          slot_act;
    logic [2:0]    bit_cnt;
    logic [6:0]    rx_sh;
    logic [63:0]   tx_sh;
    logic [7:0]    crc;
    logic [6:0]    tx_idx;
    logic [CW-1:0] conv_cnt;
    logic [15:0]   temp;
    logic          fall, rise, rst_det, bit_done, byte_done, tmr_done, tx_bit, crc_fb, rx_state;
    logic [7:0]    rx_byte;

    // Falls caused by our own pull-down are not slots.
    assign fall      = sync[2] & ~sync[1] & O_ONE_WIRE;
    assign rise      = ~sync[2] & sync[1];
    assign rst_det   = rise && low_cnt >= LW'(RESET_CYC);
    assign bit_done  = slot_act && slot_cnt == SW'(SMP_CYC - 1);
    assign rx_state  = state == ROM_CMD || state == FUNC_CMD;
    assign rx_byte   = {sync[1], rx_sh};
    assign byte_done = bit_done && rx_state && bit_cnt == 3'd7;
    assign tmr_done  = tmr == TW'((state == PRES_WAIT ? PW_CYC : PL_CYC) - 1);
    assign tx_bit    = tx_idx < 7'd64 ? tx_sh[0] : tx_idx < 7'd72 ? crc[0] : 1'b1;
    assign crc_fb    = crc[0] ^ tx_sh[0];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        if (rst_det)                                state_nx = PRES_WAIT;
        else if (state == PRES_WAIT && tmr_done)    state_nx = PRESENCE;
        else if (state == PRESENCE && tmr_done)     state_nx = ROM_CMD;
        else if (byte_done && state == ROM_CMD)     state_nx = rx_byte == 8'hCC ? FUNC_CMD : IDLE;
        else if (byte_done)                         state_nx = rx_byte == 8'h44 ? CONVERT :
                                                               rx_byte == 8'hBE ? TX : IDLE;
    end

    always_comb begin
        O_ONE_WIRE = !(state == PRESENCE ||
                       (slot_act && ((state == CONVERT && O_BUSY) || (state == TX && !tx_bit))));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync        <= '1;
            low_cnt     <= '0;
            tmr         <= '0;
            slot_cnt    <= '0;
            slot_act    <= 1'b0;
            bit_cnt     <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            crc         <= '0;
            tx_idx      <= '0;
            conv_cnt    <= '0;
            temp        <= 16'h0550;
            O_CMD       <= '0;
            O_CMD_VALID <= 1'b0;
            O_BUSY      <= 1'b0;
        end else begin
            sync        <= {sync[1:0], I_ONE_WIRE};
            low_cnt     <= sync[1] ? '0 : low_cnt + LW'(low_cnt != LW'(RESET_CYC));
            tmr         <= (rst_det || state_nx != state) ? '0 : tmr + TW'(1);
            slot_act    <= rst_det ? 1'b0 : fall ? 1'b1 : bit_done ? 1'b0 : slot_act;
            slot_cnt    <= fall ? '0 : slot_cnt + SW'(slot_act);
            O_CMD_VALID <= byte_done && state == FUNC_CMD;
            if (rst_det) bit_cnt <= '0;
            else if (bit_done && rx_state) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sh   <= rx_byte[7:1];
            end
            if (byte_done && state == FUNC_CMD) O_CMD <= rx_byte;
            if (byte_done && state == FUNC_CMD && rx_byte == 8'hBE) begin
                tx_sh  <= {48'h100C_FF7F_464B, temp};
                crc    <= '0;
                tx_idx <= '0;
            end else if (bit_done && state == TX && tx_idx != 7'd72) begin
                tx_idx <= tx_idx + 7'd1;
                tx_sh  <= tx_sh >> 1;
                crc    <= tx_idx < 7'd64 ? ({1'b0, crc[7:1]} ^ (crc_fb ? 8'h8C : 8'h00)) : crc >> 1;
            end
            // Counter stops at zero; only a new Convert T restarts it.
            if (O_CMD_VALID && O_CMD == 8'h44) begin
                O_BUSY   <= 1'b1;
                conv_cnt <= CW'(CONV_CYC - 1);
            end else if (O_BUSY) begin
                if (conv_cnt == '0) begin
                    O_BUSY <= 1'b0;
                    temp   <= I_TEMP;
                end else conv_cnt <= conv_cnt - CW'(1);
            end
        end
endmodule
